instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped, read-only instruction cache that sits directly upstream of the pipelined core's fetch stage. It returns `InstrF` combinationally for the current `PCF` on a hit. On a miss it raises `InstrMissF`, fills the whole line from a word-serial backing-memory port, and pulses `InstrCacheRepActive` during the commit cycle so the hazard unit can hold the pipeline.

## Interface
Parameters:
- `SETS`, 64: number of lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: reset is synchronous and active-low.
- `PCF`, input, 32: fetch address; bits [1:0] are ignored.
- `InvalidateI`, input, 1: one-cycle request to invalidate all lines (fence.i).
- `InstrF`, output, 32: instruction at `PCF`.
- `InstrMissF`, output, 1: `InstrF` is not valid this cycle.
- `InstrCacheRepActive`, output, 1: line commit in progress.
- `MemReq`, output, 1: line-fill request, held until `MemAck`.
- `MemAddr`, output, 32: line-aligned fill address; low `2+log2(WORDS_PER_LINE)` bits are zero.
- `MemAck`, input, 1: memory accepts the request in a cycle where `MemReq`=1.
- `MemRValid`, input, 1: one fill beat is present.
- `MemRData`, input, 32: fill beat data; beats arrive in order, word 0 first.

## Operation
- Address split:
  - offset = `PCF[2+OB-1:2]`, where OB = log2(`WORDS_PER_LINE`).
  - index = next log2(`SETS`) bits.
  - tag = the remaining upper bits.
- Storage: tag array, valid bit per set, data array. All are flop-based with combinational read.
- Hit when the line is valid, the stored tag equals the tag of `PCF`, and state is IDLE.
- FSM states are IDLE, REQ, FILL, UPDATE.
- IDLE:
  - Hit: `InstrF` = stored word, `InstrMissF`=0.
  - Miss: `InstrMissF`=1, `InstrF`=32'h0000_0013 (NOP). Latch the line address (`PCF` with offset bits cleared) and go to REQ.
- REQ: `MemReq`=1, `MemAddr`=latched line address. Go to FILL in the cycle `MemAck`=1.
- FILL:
  - Each `MemRValid` writes `MemRData` into a line buffer at the beat counter position, then the counter increments.
  - After beat `WORDS_PER_LINE`-1, go to UPDATE.
  - `MemRValid` outside FILL is ignored.
- UPDATE:
  - Write the line buffer, tag and valid=1 into the latched index. This replaces any previous line; there is no victim handling.
  - `InstrCacheRepActive`=1.
  - Go to IDLE.
- `InstrMissF`=1 and `InstrF`=NOP in every cycle of REQ, FILL and UPDATE.
- `PCF` changing during a fill (redirect) does not affect the fill: the latched address is committed. The new `PCF` is looked up on return to IDLE.
- `InvalidateI`:
  - In IDLE, clears all valid bits at the clock edge. The lookup in that same cycle still uses the old valid bits.
  - Outside IDLE, it sets a pending flag. In the UPDATE cycle the line is written, then all valid bits (including the new line) are cleared on the next edge. The pending flag is then cleared.
- Reset (`reset`=0): state=IDLE, all valid bits=0, beat counter=0, pending=0. This applies even mid-fill; the fill is aborted and no line is written.

## Timing
- Output values during reset and the first cycle after it:
  - `MemReq`=0, `MemAddr`=0, `InstrCacheRepActive`=0.
  - `InstrMissF`=1 (all lines invalid), `InstrF`=NOP.
- Hit latency: 0 cycles (combinational from `PCF`).
- Miss penalty with `MemAck` in the first REQ cycle and back-to-back beats is `WORDS_PER_LINE`+3 cycles:
  - c0: miss detected.
  - c1: REQ, acknowledged.
  - c2–c5: FILL beats.
  - c6: UPDATE.
  - c7: hit, `InstrMissF`=0.
- Wait states on `MemAck`/`MemRValid` extend REQ/FILL one cycle each.
- All state, counters and arrays update only on rising `clk`.

## Configuration
- `ICACHE_PERF_EN` defined:
  - Adds outputs `HitCount` (32 bits) and `MissCount` (32 bits). Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - `HitCount` increments on each IDLE hit cycle.
  - `MissCount` increments on each IDLE→REQ transition.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- `icache_pkg` holds:
  - the FSM state enum (`IC_IDLE`, `IC_REQ`, `IC_FILL`, `IC_UPDATE`);
  - the `NOP_INSTR` constant, 32'h0000_0013;
  - functions deriving offset, index and tag widths from the parameters.
- Sub-module `icache_fill_ctrl` contains:
  - the FSM;
  - the beat counter;
  - the line buffer and latched address;
  - the `InvalidateI` pending flag.
- The top level keeps the arrays, hit logic and output muxing.

## Test plan
- Cold miss: `PCF`=0x100, zero-wait memory returning 0xA0..0xA3 → `InstrMissF`=1 for 7 cycles, `InstrCacheRepActive`=1 in c6 only, `InstrF`=0xA0 in c7. `PCF`=0x104/0x108/0x10C then hit with 0xA1/0xA2/0xA3.
- Conflict: fill 0x100, then `PCF`=0x100+`SETS`*16 → miss and replace; returning to 0x100 misses again.
- Wait states: `MemAck` delayed 3 cycles, one gap between beats 1 and 2 → penalty 11 cycles, data is correct.
- Redirect mid-fill: miss on 0x200, `PCF` changed to 0x300 in FILL → line 0x200 is committed; 0x300 misses after UPDATE; 0x200 later hits.
- `InvalidateI`: pulsed in IDLE → next cycle a previously hitting `PCF` misses. Pulsed during FILL → line written, then all lines invalid one cycle after UPDATE.
- Reset mid-FILL after 2 beats → `MemReq`=0 and state IDLE; the same `PCF` misses and refetches all 4 beats.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REQ    = 2'd1,
    IC_FILL   = 2'd2,
    IC_UPDATE = 2'd3
  } ic_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word-offset bits within a line.
  function automatic int unsigned ic_offset_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Set-index bits.
  function automatic int unsigned ic_index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever remains above byte, offset and index fields.
  function automatic int unsigned ic_tag_bits(input int unsigned sets,
                                              input int unsigned words_per_line);
    return 32 - 2 - ic_offset_bits(words_per_line) - ic_index_bits(sets);
  endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Miss handling for the instruction cache: fill FSM, beat counter, line
// buffer, latched line address and the deferred-invalidate flag.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter  int unsigned SETS           = 64,
  parameter  int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned IB             = ic_index_bits(SETS),
  localparam int unsigned TB             = ic_tag_bits(SETS, WORDS_PER_LINE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_lookup_miss,
  input  logic [31:0]                    i_pcf_line,
  input  logic                           i_invalidate,
  input  logic                           i_mem_ack,
  input  logic                           i_mem_rvalid,
  input  logic [31:0]                    i_mem_rdata,
  output logic                           o_idle,
  output logic                           o_mem_req,
  output logic [31:0]                    o_mem_addr,
  output logic                           o_commit,
  output logic                           o_inv_all,
  output logic [IB-1:0]                  o_commit_index,
  output logic [TB-1:0]                  o_commit_tag,
  output logic [WORDS_PER_LINE*32-1:0]   o_line_data
);

  localparam int unsigned    OB        = ic_offset_bits(WORDS_PER_LINE);
  localparam logic [OB-1:0]  LAST_BEAT = OB'(WORDS_PER_LINE - 1);

  ic_state_e                      r_state;
  ic_state_e                      w_next_state;
  logic [OB-1:0]                  r_beat_cnt;
  logic [WORDS_PER_LINE-1:0][31:0] r_line_buf;
  logic [31:0]                    r_line_addr;
  logic                           r_inv_pend;
  logic                           w_beat;
  logic                           w_last_beat;

  assign w_beat      = (r_state == IC_FILL) && i_mem_rvalid;
  assign w_last_beat = w_beat && (r_beat_cnt == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IC_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_next_state = r_state;
    o_idle       = 1'b0;
    o_mem_req    = 1'b0;
    o_commit     = 1'b0;
    case (r_state)
      IC_IDLE: begin
        o_idle = 1'b1;
        if (i_lookup_miss) w_next_state = IC_REQ;
      end
      IC_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) w_next_state = IC_FILL;
      end
      IC_FILL: begin
        if (w_last_beat) w_next_state = IC_UPDATE;
      end
      IC_UPDATE: begin
        o_commit     = 1'b1;
        w_next_state = IC_IDLE;
      end
      default: w_next_state = IC_IDLE;
    endcase
  end

  // Beat counter; wraps back to zero after the last beat of a line.
  always_ff @(posedge clk) begin
    if (!reset)      r_beat_cnt <= '0;
    else if (w_beat) r_beat_cnt <= r_beat_cnt + OB'(1);
  end

  // Line address captured on the miss; later PCF redirects do not disturb it.
  always_ff @(posedge clk) begin
    if (!reset)                       r_line_addr <= '0;
    else if (o_idle && i_lookup_miss) r_line_addr <= i_pcf_line;
  end

  // Invalidate seen mid-fill is held until the first IDLE cycle after commit.
  always_ff @(posedge clk) begin
    if (!reset)            r_inv_pend <= 1'b0;
    else if (o_idle)       r_inv_pend <= 1'b0;
    else if (i_invalidate) r_inv_pend <= 1'b1;
  end

  // Line buffer collecting fill beats in arrival order.
  always_ff @(posedge clk) begin
    if (w_beat) r_line_buf[r_beat_cnt] <= i_mem_rdata;
  end

  assign o_mem_addr     = o_mem_req ? r_line_addr : '0;
  assign o_inv_all      = o_idle && (i_invalidate || r_inv_pend);
  assign o_commit_index = r_line_addr[OB+2 +: IB];
  assign o_commit_tag   = r_line_addr[31 -: TB];
  assign o_line_data    = r_line_buf;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: tag/valid/data arrays, hit
// lookup and fetch output muxing; misses are handled by icache_fill_ctrl.
// Optional ICACHE_PERF_EN adds saturating HitCount/MissCount outputs.
module instr_cache
  import icache_pkg::*;
#(
  parameter int unsigned SETS           = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        InvalidateI,
  output logic [31:0] InstrF,
  output logic        InstrMissF,
  output logic        InstrCacheRepActive,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic        MemRValid,
  input  logic [31:0] MemRData
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int unsigned OB        = ic_offset_bits(WORDS_PER_LINE);
  localparam int unsigned IB        = ic_index_bits(SETS);
  localparam int unsigned TB        = ic_tag_bits(SETS, WORDS_PER_LINE);
  localparam logic [31:0] LINE_MASK = 32'((64'd1 << (OB + 2)) - 64'd1);

  logic [SETS-1:0]                 r_valid;
  logic [TB-1:0]                   r_tag  [SETS];
  logic [WORDS_PER_LINE-1:0][31:0] r_data [SETS];

  logic [31:0]                  w_pcf_line;
  logic [OB-1:0]                w_offset;
  logic [IB-1:0]                w_index;
  logic [TB-1:0]                w_tag;
  logic                         w_idle;
  logic                         w_hit;
  logic                         w_miss;
  logic                         w_commit;
  logic                         w_inv_all;
  logic [IB-1:0]                w_commit_index;
  logic [TB-1:0]                w_commit_tag;
  logic [WORDS_PER_LINE*32-1:0] w_line_data;

  assign w_pcf_line = PCF & ~LINE_MASK;
  assign w_offset   = PCF[2 +: OB];
  assign w_index    = w_pcf_line[OB+2 +: IB];
  assign w_tag      = w_pcf_line[31 -: TB];

  assign w_hit  = w_idle && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss = w_idle && !w_hit;

  icache_fill_ctrl #(
    .SETS           (SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_fill_ctrl (
    .clk            (clk),
    .reset          (reset),
    .i_lookup_miss  (w_miss),
    .i_pcf_line     (w_pcf_line),
    .i_invalidate   (InvalidateI),
    .i_mem_ack      (MemAck),
    .i_mem_rvalid   (MemRValid),
    .i_mem_rdata    (MemRData),
    .o_idle         (w_idle),
    .o_mem_req      (MemReq),
    .o_mem_addr     (MemAddr),
    .o_commit       (w_commit),
    .o_inv_all      (w_inv_all),
    .o_commit_index (w_commit_index),
    .o_commit_tag   (w_commit_tag),
    .o_line_data    (w_line_data)
  );

  // Valid bits: invalidate-all only happens in IDLE, commit only in UPDATE.
  always_ff @(posedge clk) begin
    if (!reset)         r_valid <= '0;
    else if (w_inv_all) r_valid <= '0;
    else if (w_commit)  r_valid[w_commit_index] <= 1'b1;
  end

  // Tag and data arrays, written once per completed fill.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_tag[w_commit_index]  <= w_commit_tag;
      r_data[w_commit_index] <= w_line_data;
    end
  end

  // Fetch output: stored word on a hit, NOP otherwise.
  always_comb begin
    InstrF     = NOP_INSTR;
    InstrMissF = 1'b1;
    if (w_hit) begin
      InstrF     = r_data[w_index][w_offset];
      InstrMissF = 1'b0;
    end
  end

  assign InstrCacheRepActive = w_commit;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating event counters; a lookup miss in IDLE is the IDLE->REQ edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != '1))   r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss && (r_miss_count != '1)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign HitCount  = r_hit_count;
  assign MissCount = r_miss_count;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: directed vector table, multi-cycle corner sequences
// and randomized traffic, all checked against a line-level cache model.
`timescale 1ns/1ps
module tb_instr_cache;

  localparam int unsigned SETS       = 64;
  localparam int unsigned WPL        = 4;
  localparam int unsigned LINE_BYTES = WPL * 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        InvalidateI;
  logic [31:0] InstrF;
  logic        InstrMissF;
  logic        InstrCacheRepActive;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic        MemRValid;
  logic [31:0] MemRData;

  int checks   = 0;
  int failures = 0;

  instr_cache #(
    .SETS           (SETS),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .PCF                 (PCF),
    .InvalidateI         (InvalidateI),
    .InstrF              (InstrF),
    .InstrMissF          (InstrMissF),
    .InstrCacheRepActive (InstrCacheRepActive),
    .MemReq              (MemReq),
    .MemAddr             (MemAddr),
    .MemAck              (MemAck),
    .MemRValid           (MemRValid),
    .MemRData            (MemRData)
  );

  always #5 clk = ~clk;

  // Backing memory contents: line 0x100 holds 0xA0..0xA3, the rest a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= 32'h100 && w < 32'h110) return 32'hA0 + ((w - 32'h100) >> 2);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return int'((a / 32'(LINE_BYTES)) % 32'(SETS));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          cfg_ack_delay     = 0;
  int          cfg_gap_beat      = -1;
  bit          cfg_random        = 0;
  int          resp_beat         = -1;
  int          resp_req_wait     = 0;
  bit          resp_gap_done     = 0;
  logic [31:0] resp_addr         = '0;
  int          resp_beats_total  = 0;

  initial begin
    MemAck    = 1'b0;
    MemRValid = 1'b0;
    MemRData  = '0;
    forever begin
      @(negedge clk);
      MemAck    = 1'b0;
      MemRValid = 1'b0;
      MemRData  = '0;
      if (reset !== 1'b1) begin
        resp_beat     = -1;
        resp_req_wait = 0;
      end else if (resp_beat >= 0) begin
        if ((cfg_random && $urandom_range(0, 3) == 0) ||
            (!cfg_random && resp_beat == cfg_gap_beat && !resp_gap_done)) begin
          resp_gap_done = 1;
        end else begin
          MemRValid = 1'b1;
          MemRData  = mem_word(resp_addr + 32'(resp_beat * 4));
          resp_beat++;
          resp_beats_total++;
          if (resp_beat == WPL) resp_beat = -1;
        end
      end else if (MemReq === 1'b1) begin
        if (cfg_random ? ($urandom_range(0, 2) == 0) : (resp_req_wait >= cfg_ack_delay)) begin
          MemAck        = 1'b1;
          resp_addr     = MemAddr;
          resp_beat     = 0;
          resp_gap_done = 0;
          resp_req_wait = 0;
        end else begin
          resp_req_wait++;
          if (cfg_random && $urandom_range(0, 3) == 0) begin
            MemRValid = 1'b1;
            MemRData  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
          end
        end
      end else if (cfg_random && $urandom_range(0, 3) == 0) begin
        MemRValid = 1'b1;
        MemRData  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end
    end
  end

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_WAIT, M_COMMIT} mmode_e;
  mmode_e      m_mode  = M_IDLE;
  bit          m_known = 0;
  bit          m_acked = 0;
  int          m_beats = 0;
  bit          m_pend  = 0;
  logic [31:0] m_fill  = '0;
  bit          m_valid [SETS];
  logic [31:0] m_line  [SETS];

  // One cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input logic [31:0] pcf, input logic inv, input logic rst_n);
    bit          hit;
    bit          req;
    int unsigned ix;
    logic [31:0] ln;
    @(negedge clk);
    PCF         = pcf;
    InvalidateI = inv;
    reset       = rst_n;
    #1;
    ln  = line_of(pcf);
    ix  = idx_of(pcf);
    hit = (m_mode == M_IDLE) && m_valid[ix] && (m_line[ix] == ln);
    req = (m_mode == M_WAIT) && !m_acked;
    if (m_known) begin
      chk("model_miss",    32'(InstrMissF),          32'(!hit));
      chk("model_instr",   InstrF,                   hit ? mem_word(pcf) : NOP);
      chk("model_rep",     32'(InstrCacheRepActive), 32'(m_mode == M_COMMIT));
      chk("model_memreq",  32'(MemReq),              32'(req));
      chk("model_memaddr", MemAddr,                  req ? m_fill : 32'h0);
    end
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_pend  = 0;
      m_known = 1;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else if (m_known) begin
      case (m_mode)
        M_IDLE: begin
          if (inv || m_pend) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_pend = 0;
          end
          if (!hit) begin
            m_mode  = M_WAIT;
            m_fill  = ln;
            m_acked = 0;
            m_beats = 0;
          end
        end
        M_WAIT: begin
          if (inv) m_pend = 1;
          if (!m_acked) begin
            if (MemAck) m_acked = 1;
          end else if (MemRValid) begin
            m_beats++;
            if (m_beats == WPL) m_mode = M_COMMIT;
          end
        end
        default: begin
          if (inv) m_pend = 1;
          m_valid[idx_of(m_fill)] = 1;
          m_line[idx_of(m_fill)]  = m_fill;
          m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  // Hold PCF until it hits; checks the number of miss cycles seen.
  task automatic wait_hit(input logic [31:0] pcf, input int unsigned exp_cycles, input string name);
    int unsigned n;
    n = 0;
    step(pcf, 1'b0, 1'b1);
    while (InstrMissF && n < 100) begin
      n++;
      step(pcf, 1'b0, 1'b1);
    end
    chk(name, n, exp_cycles);
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pcf;
    logic        inv;
    logic        miss;
    logic        rep;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] pool [8];
  logic [31:0] cur;
  int          beats0;

  initial begin
    reset       = 1'b0;
    PCF         = '0;
    InvalidateI = 1'b0;

    // Cold miss on 0x100 with a zero-wait memory, then the rest of the line.
    //            rst   pcf       inv   miss  rep   req   addr      instr
    tbl[0]  = '{1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   NOP};
    tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   NOP};
    tbl[2]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, NOP};
    tbl[3]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   NOP};
    tbl[4]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   NOP};
    tbl[5]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   NOP};
    tbl[6]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   NOP};
    tbl[7]  = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   NOP};
    tbl[8]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hA0};
    tbl[9]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hA1};
    tbl[10] = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hA2};
    tbl[11] = '{1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hA3};

    step(32'h100, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].pcf, tbl[i].inv, tbl[i].rst);
      chk($sformatf("vec%0d_miss", i),  32'(InstrMissF),          32'(tbl[i].miss));
      chk($sformatf("vec%0d_rep", i),   32'(InstrCacheRepActive), 32'(tbl[i].rep));
      chk($sformatf("vec%0d_req", i),   32'(MemReq),              32'(tbl[i].req));
      chk($sformatf("vec%0d_addr", i),  MemAddr,                  tbl[i].addr);
      chk($sformatf("vec%0d_instr", i), InstrF,                   tbl[i].instr);
    end

    // Conflict: same index, different tag evicts 0x100.
    wait_hit(32'h100 + 32'(SETS * 16), 7, "conflict_fill");
    wait_hit(32'h100, 7, "conflict_refill");
    chk("conflict_data", InstrF, 32'hA0);

    // Wait states: ack after 3 extra REQ cycles, one gap before beat 2.
    cfg_ack_delay = 3;
    cfg_gap_beat  = 2;
    wait_hit(32'h700, 11, "waitstate_penalty");
    chk("waitstate_w0", InstrF, mem_word(32'h700));
    step(32'h708, 1'b0, 1'b1);
    chk("waitstate_w2", InstrF, mem_word(32'h708));
    cfg_ack_delay = 0;
    cfg_gap_beat  = -1;

    // Redirect during FILL: 0x200 still commits, 0x300 misses afterwards.
    step(32'h200, 1'b0, 1'b1);
    step(32'h200, 1'b0, 1'b1);
    step(32'h200, 1'b0, 1'b1);
    step(32'h300, 1'b0, 1'b1);
    step(32'h300, 1'b0, 1'b1);
    step(32'h300, 1'b0, 1'b1);
    step(32'h300, 1'b0, 1'b1);
    chk("redirect_commit", 32'(InstrCacheRepActive), 32'd1);
    wait_hit(32'h300, 7, "redirect_new_miss");
    step(32'h204, 1'b0, 1'b1);
    chk("redirect_old_hit", 32'(InstrMissF), 32'd0);
    chk("redirect_old_data", InstrF, mem_word(32'h204));

    // Invalidate in IDLE: same-cycle lookup uses old valid bits.
    step(32'h204, 1'b1, 1'b1);
    chk("inv_idle_same_cycle", 32'(InstrMissF), 32'd0);
    step(32'h204, 1'b0, 1'b1);
    chk("inv_idle_next_miss", 32'(InstrMissF), 32'd1);
    wait_hit(32'h204, 6, "inv_idle_refill");

    // Invalidate during FILL: new line visible for one cycle, then all gone.
    step(32'h400, 1'b0, 1'b1);
    step(32'h400, 1'b0, 1'b1);
    step(32'h400, 1'b1, 1'b1);
    step(32'h400, 1'b0, 1'b1);
    step(32'h400, 1'b0, 1'b1);
    step(32'h400, 1'b0, 1'b1);
    step(32'h400, 1'b0, 1'b1);
    chk("inv_fill_commit", 32'(InstrCacheRepActive), 32'd1);
    step(32'h400, 1'b0, 1'b1);
    chk("inv_fill_line_visible", 32'(InstrMissF), 32'd0);
    step(32'h200, 1'b0, 1'b1);
    chk("inv_fill_old_cleared", 32'(InstrMissF), 32'd1);
    wait_hit(32'h200, 6, "inv_fill_refill_old");
    step(32'h400, 1'b0, 1'b1);
    chk("inv_fill_new_cleared", 32'(InstrMissF), 32'd1);
    wait_hit(32'h400, 6, "inv_fill_refill_new");

    // Reset after two beats of a fill aborts it; the line is refetched whole.
    step(32'h600, 1'b0, 1'b1);
    step(32'h600, 1'b0, 1'b1);
    step(32'h600, 1'b0, 1'b1);
    step(32'h600, 1'b0, 1'b1);
    step(32'h600, 1'b0, 1'b0);
    step(32'h600, 1'b0, 1'b0);
    chk("rst_mid_memreq", 32'(MemReq), 32'd0);
    chk("rst_mid_miss", 32'(InstrMissF), 32'd1);
    beats0 = resp_beats_total;
    wait_hit(32'h600, 7, "rst_refetch_penalty");
    chk("rst_refetch_beats", 32'(resp_beats_total - beats0), 32'd4);
    chk("rst_refetch_w0", InstrF, mem_word(32'h600));
    step(32'h60C, 1'b0, 1'b1);
    chk("rst_refetch_w3", InstrF, mem_word(32'h60C));

    // Randomized traffic: conflicting lines, random waits, stray beats,
    // occasional invalidates and resets.
    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0000_0500;
    pool[2] = 32'h0000_0900;
    pool[3] = 32'h0000_0200;
    pool[4] = 32'h0000_1200;
    pool[5] = 32'h4000_0040;
    pool[6] = 32'h0000_2000;
    pool[7] = 32'h0000_7FF0;
    cfg_random = 1;
    cur = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) cur = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) begin
        step(cur, 1'b0, 1'b0);
        step(cur, 1'b0, 1'b0);
      end else begin
        step(cur, ($urandom_range(0, 39) == 0), 1'b1);
      end
    end
    cfg_random = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
